mod_sub: RTL and testbench

MOD_SUB -- requirements
Module: mod_sub

---
 rtl/mod_sub.sv | 37 +++
 tb/tb_mod_sub.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mod_sub.sv
// mod_sub: registered modular subtraction c = (a - b) mod q, one-cycle latency.
// Operands may reach 2q-1; two conditional corrections bring the difference into range.
module mod_sub #(
    parameter int QW = 23
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          valid_i,
    input  logic [QW:0]   a_i,
    input  logic [QW:0]   b_i,
    input  logic [QW-1:0] q_i,
    output logic          valid_o,
    output logic [QW-1:0] c_o
);
    logic signed [QW+1:0] q_s, d, d1, d2;
    logic [QW-1:0] c_d, c_q;
    logic valid_q;
    always_comb begin
        q_s = $signed({2'b00, q_i});
        d   = $signed({1'b0, a_i}) - $signed({1'b0, b_i});
        // negative differences climb up by q, large ones come down by q, at most twice
        d1  = d[QW+1] ? d + q_s : (d >= q_s ? d - q_s : d);
        d2  = d[QW+1] ? (d1[QW+1] ? d1 + q_s : d1) : (d1 >= q_s ? d1 - q_s : d1);
        c_d = (q_i == '0) ? '0 : d2[QW-1:0];
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            c_q     <= '0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) c_q <= c_d;
        end
    end
    assign valid_o = valid_q;
    assign c_o     = c_q;
endmodule

// File: tb/tb_mod_sub.sv
// tb_mod_sub: scoreboard bench for mod_sub; expected results queued at drive time.
module tb_mod_sub;
    localparam int QW = 23;
    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          valid_i = 1'b0;
    logic [QW:0]   a_i = '0;
    logic [QW:0]   b_i = '0;
    logic [QW-1:0] q_i = '0;
    logic          valid_o;
    logic [QW-1:0] c_o;
    int n_checks = 0;
    int n_errors = 0;
    logic [QW-1:0] sb[$];
    logic [QW-1:0] last_c = '0;

    mod_sub #(.QW(QW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
        .a_i(a_i), .b_i(b_i), .q_i(q_i),
        .valid_o(valid_o), .c_o(c_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [QW-1:0] model(input longint a, input longint b, input longint q);
        longint d;
        if (q == 0) return '0;
        if (a < 2 * q && b < 2 * q) begin
            d = ((a - b) % q + q) % q;
            return d[QW-1:0];
        end
        d = a - b;
        if (d < 0) begin
            d += q;
            if (d < 0) d += q;
        end else if (d >= q) begin
            d -= q;
            if (d >= q) d -= q;
        end
        return d[QW-1:0];
    endfunction

    task automatic step(input string tag, input logic v, input logic [QW:0] a,
                        input logic [QW:0] b, input logic [QW-1:0] q);
        valid_i = v;
        a_i = a;
        b_i = b;
        q_i = q;
        if (v) sb.push_back(model(longint'(a), longint'(b), longint'(q)));
        @(posedge clk_i);
        #1;
        check({tag, "_valid"}, {31'd0, valid_o}, {31'd0, v});
        if (valid_o) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s_sb: result with empty scoreboard, got %0d", tag, c_o);
            end else begin
                last_c = sb.pop_front();
                check({tag, "_c"}, {9'd0, c_o}, {9'd0, last_c});
            end
        end else begin
            check({tag, "_hold"}, {9'd0, c_o}, {9'd0, last_c});
        end
    endtask

    initial begin
        logic [QW-1:0] q;
        logic [QW:0] a, b;
        #1;
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_c", {9'd0, c_o}, 32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        step("idle", 1'b0, 24'd5, 24'd3, 23'd40);
        step("zero", 1'b1, 24'd0, 24'd0, 23'd40);
        step("b2b0", 1'b1, 24'd20, 24'd13, 23'd40);
        step("b2b1", 1'b1, 24'd7, 24'd13, 23'd40);
        step("top_a", 1'b1, 24'd79, 24'd0, 23'd40);
        step("top_b", 1'b1, 24'd0, 24'd79, 23'd40);
        step("top_ab", 1'b1, 24'd79, 24'd79, 23'd40);
        step("qmax", 1'b1, 24'd16777213, 24'd0, 23'd8388607);
        step("q0", 1'b1, 24'd5, 24'd3, 23'd0);
        step("eq", 1'b1, 24'd12345, 24'd12345, 23'd777);
        step("nz", 1'b1, 24'd20, 24'd13, 23'd40);
        for (int i = 0; i < 3; i++) step("gap", 1'b0, 24'(i * 7 + 1), 24'd2, 23'd9);
        for (int i = 0; i < 40; i++) begin
            q = 23'($urandom_range(1, 8388607));
            a = 24'($urandom_range(0, 2 * int'(q) - 1));
            b = 24'($urandom_range(0, 2 * int'(q) - 1));
            step("rnd", 1'b1, a, b, q);
        end
        for (int i = 0; i < 20; i++) begin
            q = 23'($urandom_range(1, 1000));
            a = 24'($urandom);
            b = 24'($urandom);
            step("oor", ($urandom_range(0, 3) != 0), a, b, q);
        end
        step("pre_rst", 1'b1, 24'd30, 24'd1, 23'd40);
        valid_i = 1'b1;
        a_i = 24'd25;
        b_i = 24'd3;
        q_i = 23'd40;
        #2 rst_i = 1'b1;
        #1;
        check("arst_valid", {31'd0, valid_o}, 32'd0);
        check("arst_c", {9'd0, c_o}, 32'd0);
        sb.delete();
        last_c = '0;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        step("post_rst", 1'b0, 24'd25, 24'd3, 23'd40);
        step("post_rst", 1'b0, 24'd25, 24'd3, 23'd40);
        step("first", 1'b1, 24'd50, 24'd1, 23'd40);
        step("tail", 1'b0, 24'd0, 24'd0, 23'd40);
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_drain: %0d results left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
